jump_input_conditioner: RTL and testbench
=========================================

# jump_input_conditioner

Conditions the raw "up" push-button before the processor and game logic use it as the jump input. The block synchronizes and debounces the button, then emits a single-cycle press pulse. It also holds a per-frame jump flag that stays stable for one whole frame, captured at each frame boundary from the VGA controller's screen-end signal. It sits between the board pin and the processor's `io_jump` input, replacing the direct wire.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000, number of consecutive stable cycles required to accept a press or a release (10 ms at 25 MHz). Legal range is ≥ 2.
- CNT_W, 18, width of the debounce counter. Requires 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_raw  in  1  raw button pin; asynchronous to `clock`.
- frame_tick  in  1  screen-end level from the VGA controller; synchronous to `clock`; only its rising edge is used.
- jump_level  out  1  debounced button state.
- jump_pulse  out  1  one-cycle pulse for each accepted press.
- jump_frame  out  1  press-seen-last-frame flag; changes only on a frame_tick rising edge.
- press_count  out  8  count of accepted presses; wraps from 255 to 0.

## Operation
- **Synchronizer:** 2-flop chain on `btn_raw` produces `sync`. Both flops reset to 0.
- **FSM states:** IDLE, DEB_PRESS, PRESSED, DEB_RELEASE. Encoding is 2 bits.
  - IDLE: when `sync`=1, go to DEB_PRESS and clear the counter.
  - DEB_PRESS: when `sync`=0, go to IDLE. When the counter equals DEBOUNCE_CYCLES-1 and `sync`=1, go to PRESSED. Otherwise the counter increments.
  - PRESSED: when `sync`=0, go to DEB_RELEASE and clear the counter.
  - DEB_RELEASE: when `sync`=1, go to PRESSED with no new pulse. When the counter equals DEBOUNCE_CYCLES-1 and `sync`=0, go to IDLE. Otherwise the counter increments.
- **Outputs from the FSM:**
  - `jump_level` = 1 in PRESSED and DEB_RELEASE.
  - `jump_pulse` is registered. It is 1 for exactly the cycle after the DEB_PRESS→PRESSED transition edge.
  - `press_count` increments in the same edge that sets `jump_pulse`.
- **Frame latch:** `pending` is set by `jump_pulse`. `frame_edge` = `frame_tick` & ~`frame_tick_d`. On `frame_edge`:
  - `jump_frame` <= `pending`.
  - `pending` <= `jump_pulse`. A pulse coincident with a frame edge is therefore carried into the next frame, never lost and never counted twice.
- Multiple presses within one frame collapse to a single `jump_frame`=1. `press_count` still counts every press.
- **Reset values:** all outputs are 0 after reset. The state is IDLE, the counter is 0, `pending`=0 and `frame_tick_d`=0. Reset asserted mid-debounce or mid-frame discards everything in progress, with no pulse.

## Timing
- Press latency: `btn_raw` stable high before edge 0 → `sync`=1 after edge 1 → DEB_PRESS after edge 2 → PRESSED, `jump_pulse`=1 and `jump_level`=1 after edge 2+DEBOUNCE_CYCLES. The pulse lasts 1 cycle.
- Release latency: `jump_level` falls DEBOUNCE_CYCLES+2 cycles after `btn_raw` goes stably low.
- A glitch shorter than DEBOUNCE_CYCLES cycles (as seen at `sync`) produces no output change.
- `jump_frame` updates 1 cycle after the `frame_tick` rising edge is sampled. It is held constant until the next rising edge.
- The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- No throughput limit beyond debounce: the minimum press-to-press spacing is 2·DEBOUNCE_CYCLES+2 cycles.

## Structure
- Shared game package holds the FSM state typedef/localparams (`ST_IDLE`, `ST_DEB_PRESS`, `ST_PRESSED`, `ST_DEB_RELEASE`) and the default DEBOUNCE_CYCLES constant, for reuse with the "down" button.
- One natural sub-module: `sync_2ff`, the synchronizer, reusable for `down`.
- The top level instantiates this block once per button, with `up`'s `jump_frame` driving `io_jump`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Clean press:** `btn_raw` 0→1 held 20 cycles → `jump_pulse` is high exactly once, after edge 6 relative to the first high sample. `jump_level`=1 and `press_count`=1.
- **Bounce:** `btn_raw` high 3 cycles, low 1, high 2, low → no `jump_pulse`, `jump_level` stays 0 and `press_count`=0.
- **Release bounce:** while PRESSED, `btn_raw` low 2 cycles then high → `jump_level` stays 1 and no second pulse. A stable low then gives `jump_level`=0 six cycles later.
- **Frame latch:** press, then a `frame_tick` edge → `jump_frame`=1 for the whole following frame. The next edge, with no press, → `jump_frame`=0.
- **Coincident events:** `jump_pulse` in the same cycle as `frame_edge` → `jump_frame` takes the old `pending` (0). The next frame edge gives `jump_frame`=1.
- **Reset and wrap:** assert reset mid-DEB_PRESS → all outputs 0 and no pulse after release of reset. Then 256 presses → `press_count` wraps to 0.

Source files
------------

// File: rtl/jump_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jump_input_conditioner_pkg
//  Description : Shared button-conditioning state encoding and default
//                debounce constants, reused by the up and down buttons.
//  Revision    : 1.0 - initial release
// ============================================================================
package jump_input_conditioner_pkg;

    // 10 ms at 25 MHz
    localparam int unsigned c_DEBOUNCE_CYCLES_DEFAULT = 250000;
    localparam int unsigned c_CNT_W_DEFAULT           = 18;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE        = 2'd0;
    localparam state_t ST_DEB_PRESS   = 2'd1;
    localparam state_t ST_PRESSED     = 2'd2;
    localparam state_t ST_DEB_RELEASE = 2'd3;

    // Debounced level as seen from the state: high once a press is accepted
    function automatic logic state_is_down(input state_t st);
        return (st == ST_PRESSED) || (st == ST_DEB_RELEASE);
    endfunction

endpackage : jump_input_conditioner_pkg
`default_nettype wire

// File: rtl/jump_input_conditioner_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous input bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/jump_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : jump_input_conditioner
//  Description : Synchronizes and debounces the jump button, emits a press
//                pulse and count, and latches a per-frame jump flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module jump_input_conditioner
    import jump_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = c_CNT_W_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       frame_tick,
    output logic       jump_level,
    output logic       jump_pulse,
    output logic       jump_frame,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync;
    logic             w_frame_edge;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;
    logic [7:0]       r_count;

    logic             r_frame_tick_d;
    logic             r_pending;
    logic             r_frame;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .i_d   (btn_raw),
        .o_q   (w_sync)
    );

    // Debounce FSM: a level change is accepted only after the counter sees
    // the new value held through DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_count <= 8'd0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sync) begin
                        r_state <= ST_DEB_PRESS;
                        r_cnt   <= '0;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!w_sync) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_PRESSED;
                        r_level <= 1'b1;
                        r_pulse <= 1'b1;
                        r_count <= r_count + 8'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!w_sync) begin
                        r_state <= ST_DEB_RELEASE;
                        r_cnt   <= '0;
                    end
                end
                ST_DEB_RELEASE: begin
                    // Bounce back to pressed keeps the level and raises no pulse
                    if (w_sync) begin
                        r_state <= ST_PRESSED;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_level <= state_is_down(ST_IDLE);
                end
            endcase
        end
    end

    assign w_frame_edge = frame_tick & ~r_frame_tick_d;

    // A pulse coincident with the frame edge lands in the next frame's pending
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frame_tick_d <= 1'b0;
            r_pending      <= 1'b0;
            r_frame        <= 1'b0;
        end else begin
            r_frame_tick_d <= frame_tick;
            if (w_frame_edge) begin
                r_frame   <= r_pending;
                r_pending <= r_pulse;
            end else if (r_pulse) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign jump_level  = r_level;
    assign jump_pulse  = r_pulse;
    assign jump_frame  = r_frame;
    assign press_count = r_count;

endmodule : jump_input_conditioner
`default_nettype wire

// File: tb/tb_jump_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jump_input_conditioner
//  Description : Randomized self-checking bench for jump_input_conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_input_conditioner;

    localparam int D = 4;

    logic       clock      = 1'b0;
    logic       reset      = 1'b0;
    logic       btn_raw    = 1'b0;
    logic       frame_tick = 1'b0;
    logic       jump_level;
    logic       jump_pulse;
    logic       jump_frame;
    logic [7:0] press_count;

    int tests    = 0;
    int failures = 0;

    // Reference model state
    bit         dly[$];
    int         run;
    bit         m_level, m_pulse, m_frame, m_seen, m_ft_prev;
    logic [7:0] m_count;

    jump_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .frame_tick  (frame_tick),
        .jump_level  (jump_level),
        .jump_pulse  (jump_pulse),
        .jump_frame  (jump_frame),
        .press_count (press_count)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        dly = {};
        dly.push_back(1'b0);
        dly.push_back(1'b0);
        run = 0;
        m_level = 0; m_pulse = 0; m_frame = 0; m_seen = 0; m_ft_prev = 0;
        m_count = 8'd0;
    endtask

    // The button reaches the debouncer two edges late; a new level is
    // accepted once it has been seen D+1 edges in a row.
    task automatic model_step(input bit b, input bit f);
        bit s, fe, prev_pulse;
        s = dly.pop_front();
        dly.push_back(b);
        prev_pulse = m_pulse;
        fe = f && !m_ft_prev;
        m_ft_prev = f;
        m_pulse = 0;
        if (s != m_level) begin
            run++;
            if (run == D + 1) begin
                m_level = s;
                run = 0;
                if (s) begin
                    m_pulse = 1;
                    m_count++;
                end
            end
        end else begin
            run = 0;
        end
        if (fe) begin
            m_frame = m_seen;
            m_seen  = prev_pulse;
        end else if (prev_pulse) begin
            m_seen = 1;
        end
    endtask

    task automatic cycle(input bit b, input bit f);
        btn_raw    = b;
        frame_tick = f;
        @(posedge clock);
        model_step(b, f);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        btn_raw = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests++;
        if ({jump_level, jump_pulse, jump_frame, press_count} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state got %b_%b_%b_%0d want all zero",
                     jump_level, jump_pulse, jump_frame, press_count);
        end
        btn_raw = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int pidx = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0);
            tests++;
            if ({jump_level, jump_pulse, jump_frame, press_count} !== {m_level, m_pulse, m_frame, m_count}) begin
                failures++;
                $display("FAIL clean_press cyc=%0d got %b_%b_%b_%0d want %b_%b_%b_%0d", i,
                         jump_level, jump_pulse, jump_frame, press_count, m_level, m_pulse, m_frame, m_count);
            end
            if (jump_pulse) begin
                pulses++;
                if (pidx < 0) pidx = i;
            end
        end
        tests++;
        if (pulses !== 1 || pidx !== 6) begin
            failures++;
            $display("FAIL clean_press_pulse got count=%0d at=%0d want count=1 at=6", pulses, pidx);
        end
        tests++;
        if (jump_level !== 1'b1 || press_count !== 8'd1) begin
            failures++;
            $display("FAIL clean_press_level got lvl=%b cnt=%0d want lvl=1 cnt=1", jump_level, press_count);
        end
        repeat (20) cycle(0, 0);
    endtask

    task automatic test_bounce();
        bit pat[] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [7:0] cnt0 = press_count;
        int pulses = 0;
        for (int i = 0; i < pat.size(); i++) begin
            cycle(pat[i], 0);
            tests++;
            if ({jump_level, jump_pulse, jump_frame, press_count} !== {m_level, m_pulse, m_frame, m_count}) begin
                failures++;
                $display("FAIL bounce cyc=%0d got %b_%b_%b_%0d want %b_%b_%b_%0d", i,
                         jump_level, jump_pulse, jump_frame, press_count, m_level, m_pulse, m_frame, m_count);
            end
            if (jump_pulse || jump_level) pulses++;
        end
        tests++;
        if (pulses !== 0 || press_count !== cnt0) begin
            failures++;
            $display("FAIL bounce_quiet got activity=%0d cnt=%0d want activity=0 cnt=%0d", pulses, press_count, cnt0);
        end
    endtask

    task automatic test_release_bounce();
        int pulses = 0;
        repeat (10) cycle(1, 0);
        for (int i = 0; i < 10; i++) begin
            cycle((i >= 2), 0);
            tests++;
            if ({jump_level, jump_pulse, jump_frame, press_count} !== {m_level, m_pulse, m_frame, m_count}) begin
                failures++;
                $display("FAIL release_bounce cyc=%0d got %b_%b_%b_%0d want %b_%b_%b_%0d", i,
                         jump_level, jump_pulse, jump_frame, press_count, m_level, m_pulse, m_frame, m_count);
            end
            if (jump_pulse || !jump_level) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL release_bounce_hold got glitches=%0d want 0", pulses);
        end
        for (int i = 0; i < 12; i++) begin
            bit exp_l;
            cycle(0, 0);
            exp_l = (i < 6);
            tests++;
            if (jump_level !== exp_l) begin
                failures++;
                $display("FAIL release_latency cyc=%0d got lvl=%b want lvl=%b", i, jump_level, exp_l);
            end
        end
    endtask

    task automatic test_frame_latch();
        cycle(0, 1); repeat (3) cycle(0, 0);
        cycle(0, 1); repeat (3) cycle(0, 0);
        repeat (10) cycle(1, 0);
        repeat (10) cycle(0, 0);
        cycle(0, 1);
        for (int i = 0; i < 14; i++) begin
            tests++;
            if (jump_frame !== 1'b1 || jump_frame !== m_frame) begin
                failures++;
                $display("FAIL frame_hold cyc=%0d got frm=%b want frm=1", i, jump_frame);
            end
            cycle(0, (i < 5));
        end
        cycle(0, 1);
        tests++;
        if (jump_frame !== 1'b0) begin
            failures++;
            $display("FAIL frame_clear got frm=%b want frm=0", jump_frame);
        end
        repeat (3) cycle(0, 0);
    endtask

    task automatic test_coincident();
        for (int i = 0; i < 7; i++) cycle(1, 0);
        tests++;
        if (jump_pulse !== 1'b1) begin
            failures++;
            $display("FAIL coincident_setup got pls=%b want pls=1", jump_pulse);
        end
        cycle(1, 1);
        tests++;
        if (jump_frame !== 1'b0 || jump_frame !== m_frame) begin
            failures++;
            $display("FAIL coincident_old got frm=%b want frm=0", jump_frame);
        end
        repeat (4) cycle(1, 0);
        repeat (10) cycle(0, 0);
        cycle(0, 1);
        tests++;
        if (jump_frame !== 1'b1 || jump_frame !== m_frame) begin
            failures++;
            $display("FAIL coincident_carry got frm=%b want frm=1", jump_frame);
        end
        repeat (3) cycle(0, 0);
    endtask

    task automatic test_random();
        bit b = 0;
        bit f = 0;
        int left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left == 0) begin
                b = $urandom_range(0, 1);
                left = $urandom_range(1, 12);
            end
            left--;
            if ($urandom_range(0, 15) == 0) f = !f;
            cycle(b, f);
            tests++;
            if ({jump_level, jump_pulse, jump_frame, press_count} !== {m_level, m_pulse, m_frame, m_count}) begin
                failures++;
                $display("FAIL random cyc=%0d got %b_%b_%b_%0d want %b_%b_%b_%0d", i,
                         jump_level, jump_pulse, jump_frame, press_count, m_level, m_pulse, m_frame, m_count);
            end
        end
        repeat (20) cycle(0, 0);
    endtask

    task automatic test_reset_wrap();
        bit f = 0;
        int pulses = 0;
        repeat (4) cycle(1, 0);
        reset = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({jump_level, jump_pulse, jump_frame, press_count} !== 11'd0) begin
            failures++;
            $display("FAIL mid_reset got %b_%b_%b_%0d want all zero",
                     jump_level, jump_pulse, jump_frame, press_count);
        end
        btn_raw = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0);
            if (jump_pulse || jump_level || press_count != 8'd0) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL post_reset_quiet got activity=%0d want 0", pulses);
        end
        for (int p = 0; p < 256; p++) begin
            int hi = $urandom_range(7, 10);
            int lo = $urandom_range(7, 10);
            for (int i = 0; i < hi + lo; i++) begin
                if ($urandom_range(0, 7) == 0) f = !f;
                cycle((i < hi), f);
                tests++;
                if ({jump_level, jump_pulse, jump_frame, press_count} !== {m_level, m_pulse, m_frame, m_count}) begin
                    failures++;
                    $display("FAIL wrap press=%0d cyc=%0d got %b_%b_%b_%0d want %b_%b_%b_%0d", p, i,
                             jump_level, jump_pulse, jump_frame, press_count, m_level, m_pulse, m_frame, m_count);
                end
            end
        end
        tests++;
        if (press_count !== 8'd0) begin
            failures++;
            $display("FAIL wrap_count got cnt=%0d want cnt=0", press_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_frame_latch();
        test_coincident();
        test_random();
        test_reset_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule : tb_jump_input_conditioner
`default_nettype wire
